xor_bind_monitor: RTL and testbench

Passive checker bound onto an instance that implements `c = a ^ b`, such as a leaf cell inside a named generate block. It is the observing end of that interface: it samples `a`, `b` and `c` with no write-back path. The reference value is delayed to match the target's pipeline latency, and the monitor counts checks and mismatches and raises a sticky error. It adds no logic to the observed path and is elaborated only through `bind`.

---
 rtl/xor_bind_monitor.sv | 225 ++++++++++++++++++++++
 tb/tb_xor_bind_monitor.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/xor_bind_monitor.sv
// Passive bind-only checker for a cell computing c = a ^ b, with a latency-matched reference pipe.
// Define XOR_MON_CAPTURE_EN to add the first-mismatch capture ports (first_err_cyc, first_err_abc).
module xor_bind_monitor #(
   parameter int LAT         = 0,
   parameter int CNT_W       = 16,
   parameter bit STOP_ON_ERR = 1'b0
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             clr,
   input  logic             a,
   input  logic             b,
   input  logic             c,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic             err,
   output logic             busy,
   output logic             halted
`ifdef XOR_MON_CAPTURE_EN
   ,
   output logic [CNT_W-1:0] first_err_cyc,
   output logic [2:0]       first_err_abc
`endif
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_HALT = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic             halt_st;
   logic             tail_vld;
   logic             tail_exp;
   logic             any_vld;
   logic             cmp_fire;
   logic             mismatch;
   logic [CNT_W-1:0] chk_cnt_reg;
   logic [CNT_W-1:0] err_cnt_reg;
   logic             err_reg;
`ifdef XOR_MON_CAPTURE_EN
   logic             tail_a;
   logic             tail_b;
   logic [CNT_W-1:0] first_cyc_reg;
   logic [2:0]       first_abc_reg;
`endif

   assign halt_st = (state_reg == ST_HALT);

   if (LAT < 0 || LAT > 7) begin : g_bad_lat
      $error("xor_bind_monitor: LAT=%0d is outside the legal range 0..7", LAT);
   end

   if (LAT == 0) begin : g_nopipe
      assign tail_vld = en;
      assign tail_exp = a ^ b;
      assign any_vld  = 1'b0;
`ifdef XOR_MON_CAPTURE_EN
      assign tail_a   = a;
      assign tail_b   = b;
`endif
   end else begin : g_pipe
      logic           flush;
      logic           push;
      logic [LAT-1:0] vld_reg;
      logic [LAT-1:0] vld_next;
      logic [LAT-1:0] exp_reg;
      logic [LAT-1:0] exp_next;
`ifdef XOR_MON_CAPTURE_EN
      logic [LAT-1:0] a_reg;
      logic [LAT-1:0] a_next;
      logic [LAT-1:0] b_reg;
      logic [LAT-1:0] b_next;
`endif

      // Halt drains the pipe to invalid; clear empties it and blocks this cycle's push.
      assign flush = clr | halt_st;
      assign push  = en & ~flush;

      for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
         if (gi == 0) begin : g_head
            assign vld_next[gi] = push;
            assign exp_next[gi] = a ^ b;
`ifdef XOR_MON_CAPTURE_EN
            assign a_next[gi]   = a;
            assign b_next[gi]   = b;
`endif
         end else begin : g_body
            assign vld_next[gi] = vld_reg[gi-1];
            assign exp_next[gi] = exp_reg[gi-1];
`ifdef XOR_MON_CAPTURE_EN
            assign a_next[gi]   = a_reg[gi-1];
            assign b_next[gi]   = b_reg[gi-1];
`endif
         end
      end

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            vld_reg <= '0;
            exp_reg <= '0;
         end else if (flush) begin
            vld_reg <= '0;
            exp_reg <= '0;
         end else begin
            vld_reg <= vld_next;
            exp_reg <= exp_next;
         end
      end

`ifdef XOR_MON_CAPTURE_EN
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            a_reg <= '0;
            b_reg <= '0;
         end else if (flush) begin
            a_reg <= '0;
            b_reg <= '0;
         end else begin
            a_reg <= a_next;
            b_reg <= b_next;
         end
      end

      assign tail_a = a_reg[LAT-1];
      assign tail_b = b_reg[LAT-1];
`endif

      assign tail_vld = vld_reg[LAT-1];
      assign tail_exp = exp_reg[LAT-1];
      assign any_vld  = |vld_reg;
   end

   assign cmp_fire = tail_vld & ~halt_st & ~clr;
   assign mismatch = cmp_fire & (c != tail_exp);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg <= ST_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // With LAT=0 the first compare lands while still IDLE, so a mismatch may halt from there too.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         ST_IDLE: begin
            if (mismatch && STOP_ON_ERR) begin
               state_next = ST_HALT;
            end else if (en || any_vld) begin
               state_next = ST_RUN;
            end
         end
         ST_RUN: begin
            if (mismatch && STOP_ON_ERR) begin
               state_next = ST_HALT;
            end else if (!en && !any_vld) begin
               state_next = ST_IDLE;
            end
         end
         ST_HALT: begin
            state_next = ST_HALT;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase
      if (clr) begin
         state_next = ST_IDLE;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         chk_cnt_reg <= '0;
         err_cnt_reg <= '0;
         err_reg     <= 1'b0;
      end else if (clr) begin
         chk_cnt_reg <= '0;
         err_cnt_reg <= '0;
         err_reg     <= 1'b0;
      end else begin
         if (cmp_fire && !(&chk_cnt_reg)) begin
            chk_cnt_reg <= chk_cnt_reg + CNT_W'(1);
         end
         if (mismatch) begin
            err_reg <= 1'b1;
            if (!(&err_cnt_reg)) begin
               err_cnt_reg <= err_cnt_reg + CNT_W'(1);
            end
         end
      end
   end

`ifdef XOR_MON_CAPTURE_EN
   // err_reg low means no mismatch has been seen since reset or clear.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         first_cyc_reg <= '0;
         first_abc_reg <= '0;
      end else if (clr) begin
         first_cyc_reg <= '0;
         first_abc_reg <= '0;
      end else if (mismatch && !err_reg) begin
         first_cyc_reg <= chk_cnt_reg;
         first_abc_reg <= {tail_a, tail_b, c};
      end
   end

   assign first_err_cyc = first_cyc_reg;
   assign first_err_abc = first_abc_reg;
`endif

   assign chk_cnt = chk_cnt_reg;
   assign err_cnt = err_cnt_reg;
   assign err     = err_reg;
   assign busy    = (state_reg == ST_RUN);
   assign halted  = halt_st;

endmodule

// File: tb/tb_xor_bind_monitor.sv
// Directed bench for xor_bind_monitor: several parameterisations side by side, shared clock/reset/data.
// Capture ports are exercised when XOR_MON_CAPTURE_EN is defined.
module tb_xor_bind_monitor;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   logic a = 1'b0;
   logic b = 1'b0;
   logic clr = 1'b0;

   logic en0 = 1'b0, c0 = 1'b0;
   logic en2 = 1'b0, c2 = 1'b0;
   logic ens = 1'b0, cs = 1'b0;
   logic ensat = 1'b0, csat = 1'b0;
   logic en3 = 1'b0, c3 = 1'b0;

   logic [15:0] chk0, err0, chk2, err2, chks, errs, chk3, err3;
   logic [2:0]  chksat, errsat;
   logic        ef0, busy0, hlt0, ef2, busy2, hlt2, efs, busys, hlts;
   logic        efsat, busysat, hltsat, ef3, busy3, hlt3;
`ifdef XOR_MON_CAPTURE_EN
   logic [15:0] fcyc0, fcyc2, fcycs, fcyc3;
   logic [2:0]  fcycsat;
   logic [2:0]  fabc0, fabc2, fabcs, fabcsat, fabc3;
`endif

   int n_checks = 0;
   int n_errors = 0;
   logic xh [0:15];
   logic [4:0] en_pat;

   always #5 clk = ~clk;

   xor_bind_monitor #(.LAT(0), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_lat0 (
      .clk(clk), .rst_n(rst_n), .en(en0), .clr(clr), .a(a), .b(b), .c(c0),
      .chk_cnt(chk0), .err_cnt(err0), .err(ef0), .busy(busy0), .halted(hlt0)
`ifdef XOR_MON_CAPTURE_EN
      , .first_err_cyc(fcyc0), .first_err_abc(fabc0)
`endif
   );

   xor_bind_monitor #(.LAT(2), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_lat2 (
      .clk(clk), .rst_n(rst_n), .en(en2), .clr(clr), .a(a), .b(b), .c(c2),
      .chk_cnt(chk2), .err_cnt(err2), .err(ef2), .busy(busy2), .halted(hlt2)
`ifdef XOR_MON_CAPTURE_EN
      , .first_err_cyc(fcyc2), .first_err_abc(fabc2)
`endif
   );

   xor_bind_monitor #(.LAT(1), .CNT_W(16), .STOP_ON_ERR(1'b1)) u_stop (
      .clk(clk), .rst_n(rst_n), .en(ens), .clr(clr), .a(a), .b(b), .c(cs),
      .chk_cnt(chks), .err_cnt(errs), .err(efs), .busy(busys), .halted(hlts)
`ifdef XOR_MON_CAPTURE_EN
      , .first_err_cyc(fcycs), .first_err_abc(fabcs)
`endif
   );

   xor_bind_monitor #(.LAT(0), .CNT_W(3), .STOP_ON_ERR(1'b0)) u_sat (
      .clk(clk), .rst_n(rst_n), .en(ensat), .clr(clr), .a(a), .b(b), .c(csat),
      .chk_cnt(chksat), .err_cnt(errsat), .err(efsat), .busy(busysat), .halted(hltsat)
`ifdef XOR_MON_CAPTURE_EN
      , .first_err_cyc(fcycsat), .first_err_abc(fabcsat)
`endif
   );

   xor_bind_monitor #(.LAT(3), .CNT_W(16), .STOP_ON_ERR(1'b0)) u_lat3 (
      .clk(clk), .rst_n(rst_n), .en(en3), .clr(clr), .a(a), .b(b), .c(c3),
      .chk_cnt(chk3), .err_cnt(err3), .err(ef3), .busy(busy3), .halted(hlt3)
`ifdef XOR_MON_CAPTURE_EN
      , .first_err_cyc(fcyc3), .first_err_abc(fabc3)
`endif
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end else begin
         $display("ok   %s: %0d", tag, got);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      // reset state
      repeat (2) tick();
      check("rst_chk0", 32'(chk0), 0);
      check("rst_err0", 32'(err0), 0);
      check("rst_flags0", 32'({ef0, busy0, hlt0}), 0);
      check("rst_flags3", 32'({ef3, busy3, hlt3}), 0);
      rst_n = 1'b1;

      // clean stream, LAT=0
      for (int i = 0; i < 10; i++) begin
         a = i[0]; b = i[1]; c0 = a ^ b; en0 = 1'b1;
         tick();
      end
      check("clean_busy", 32'(busy0), 1);
      en0 = 1'b0;
      tick();
      check("clean_chk", 32'(chk0), 10);
      check("clean_errcnt", 32'(err0), 0);
      check("clean_err", 32'(ef0), 0);
      check("clean_idle", 32'({busy0, hlt0}), 0);

      // clear collides with a mismatching compare, then a lone mismatch counts
      a = 1'b1; b = 1'b0; c0 = 1'b0; en0 = 1'b1; clr = 1'b1;
      tick();
      check("coll_chk", 32'(chk0), 0);
      check("coll_errcnt", 32'(err0), 0);
      check("coll_err", 32'(ef0), 0);
      clr = 1'b0;
      tick();
      check("lone_chk", 32'(chk0), 1);
      check("lone_errcnt", 32'(err0), 1);
      check("lone_err", 32'(ef0), 1);
      en0 = 1'b0;
      tick();

      // single mismatch, LAT=2: sample k is compared at edge k+2; the 4th sample (k=3) is corrupted
      for (int i = 0; i < 8; i++) begin
         if (i < 6) begin a = i[0]; b = i[1]; en2 = 1'b1; end
         else begin a = 1'b0; b = 1'b0; en2 = 1'b0; end
         xh[i] = a ^ b;
         c2 = 1'b0;
         if (i >= 2) c2 = xh[i-2] ^ (i == 5);
         tick();
         if (i == 4) begin
            check("mm_pre_err", 32'(ef2), 0);
            check("mm_pre_chk", 32'(chk2), 3);
         end
         if (i == 5) begin
            check("mm_errcnt", 32'(err2), 1);
            check("mm_err", 32'(ef2), 1);
            check("mm_chk", 32'(chk2), 4);
         end
      end
      check("mm_chk_end", 32'(chk2), 6);
      check("mm_errcnt_end", 32'(err2), 1);
      tick();
      check("mm_idle", 32'(busy2), 0);
`ifdef XOR_MON_CAPTURE_EN
      check("mm_first_cyc", 32'(fcyc2), 3);
      check("mm_first_abc", 32'(fabc2), 7);
`endif

      // stop on error, LAT=1: compares 2, 4 and 5 mismatch
      for (int i = 0; i < 7; i++) begin
         if (i < 6) begin a = i[0]; b = i[1]; ens = 1'b1; end
         else begin a = 1'b0; b = 1'b0; ens = 1'b0; end
         xh[i] = a ^ b;
         cs = 1'b0;
         if (i >= 1) cs = xh[i-1] ^ (i == 2 || i == 4 || i == 5);
         tick();
         if (i == 1) begin
            check("stop_pre_halt", 32'(hlts), 0);
            check("stop_pre_chk", 32'(chks), 1);
         end
         if (i == 2) begin
            check("stop_halt", 32'(hlts), 1);
            check("stop_errcnt", 32'(errs), 1);
         end
      end
      check("stop_halt_end", 32'(hlts), 1);
      check("stop_chk_end", 32'(chks), 2);
      check("stop_errcnt_end", 32'(errs), 1);
      check("stop_busy", 32'(busys), 0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      check("stop_clr_state", 32'({busys, hlts}), 0);
      check("stop_clr_cnt", 32'({chks, errs}), 0);
      check("stop_clr_err", 32'(efs), 0);

      // saturation, CNT_W=3, ten mismatching compares
      for (int i = 0; i < 10; i++) begin
         a = i[0]; b = i[1]; csat = ~(a ^ b); ensat = 1'b1;
         tick();
      end
      ensat = 1'b0;
      tick();
      check("sat_errcnt", 32'(errsat), 7);
      check("sat_chk", 32'(chksat), 7);
      check("sat_err", 32'(efsat), 1);

      // gapped enable, LAT=3: samples at 0,2,3 compared at edges 3,5,6
      en_pat = 5'b01101;
      for (int i = 0; i < 8; i++) begin
         a = i[0]; b = i[2];
         en3 = (i < 5) ? en_pat[i] : 1'b0;
         xh[i] = a ^ b;
         c3 = 1'b0;
         if (i >= 3) c3 = xh[i-3];
         tick();
         if (i == 4) check("gap_chk_mid", 32'(chk3), 1);
      end
      check("gap_chk", 32'(chk3), 3);
      check("gap_errcnt", 32'(err3), 0);

      // reset with samples in flight
      a = 1'b1; b = 1'b0; c3 = 1'b1; en3 = 1'b1;
      tick();
      tick();
      check("inflight_busy", 32'(busy3), 1);
      #2;
      rst_n = 1'b0;
      #1;
      check("arst_chk", 32'(chk3), 0);
      check("arst_flags", 32'({ef3, busy3, hlt3}), 0);
      en3 = 1'b0;
      c3 = 1'b0;
      tick();
      rst_n = 1'b1;
      repeat (5) tick();
      check("post_rst_chk", 32'(chk3), 0);
      check("post_rst_err", 32'({err3, 15'd0, ef3}), 0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
